shift_count_timer_ctrl: RTL and testbench



---
 rtl/shift_count_timer_ctrl_if.sv | 37 +++
 rtl/shift_count_timer_ctrl.sv | 123 ++++++++++++
 tb/tb_shift_count_timer_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_count_timer_ctrl_if.sv
// ---------------------------------------------------------------------------
// shift_count_timer_ctrl_if : serial input / datapath handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface shift_count_timer_ctrl_if;
    logic       data;
    logic [3:0] q;
    logic       ack;
    logic       shift_ena;
    logic       count_ena;
    logic       counting;
    logic       done;

    modport master (
        input  data,
        input  q,
        input  ack,
        output shift_ena,
        output count_ena,
        output counting,
        output done
    );

    modport slave (
        output data,
        output q,
        output ack,
        input  shift_ena,
        input  count_ena,
        input  counting,
        input  done
    );
endinterface

`default_nettype wire

// File: rtl/shift_count_timer_ctrl.sv
// ---------------------------------------------------------------------------
// shift_count_timer_ctrl : pattern-triggered shift/down-count timer sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_count_timer_ctrl #(
    parameter logic [3:0] PATTERN = 4'b1101,
    parameter int          TICKS   = 1000
) (
    input  wire logic              clk,
    input  wire logic              reset,
    shift_count_timer_ctrl_if.master bus
);

    localparam int TW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [TW-1:0] TICK_RELOAD = TW'(TICKS - 1);
    localparam logic [TW-1:0] TICK_ONE    = TW'(1);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_P1    = 4'd1;
    localparam logic [3:0] S_P2    = 4'd2;
    localparam logic [3:0] S_P3    = 4'd3;
    localparam logic [3:0] S_SH0   = 4'd4;
    localparam logic [3:0] S_SH1   = 4'd5;
    localparam logic [3:0] S_SH2   = 4'd6;
    localparam logic [3:0] S_SH3   = 4'd7;
    localparam logic [3:0] S_COUNT = 4'd8;
    localparam logic [3:0] S_DONE  = 4'd9;

    logic [3:0]    state_q, state_d;
    logic [TW-1:0] tick_q,  tick_d;
    logic [2:0]    match_len;

    // Longest prefix of PATTERN that is a suffix of (m matched bits + b);
    // a result of 4 means the whole pattern has been seen.
    function automatic logic [2:0] kmp_next(input logic [1:0] m, input logic b);
        logic [3:0] s;
        logic [2:0] best;
        logic       ok;
        s    = '0;
        s[0] = b;
        for (int j = 1; j < 4; j++) begin
            if (j <= int'(m)) begin
                s[j] = PATTERN[2'(3 - int'(m) + j)];
            end
        end
        best = 3'd0;
        for (int k = 1; k <= 4; k++) begin
            if (k <= int'(m) + 1) begin
                ok = 1'b1;
                for (int t = 0; t < 4; t++) begin
                    if (t < k) begin
                        if (s[2'(k - 1 - t)] != PATTERN[2'(3 - t)]) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = 3'(k);
                end
            end
        end
        return best;
    endfunction

    assign match_len = kmp_next(state_q[1:0], bus.data);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        case (state_q)
            S_IDLE, S_P1, S_P2, S_P3: begin
                if (match_len == 3'd4) begin
                    state_d = S_SH0;
                end else begin
                    state_d = {2'b00, match_len[1:0]};
                end
            end
            S_SH0: state_d = S_SH1;
            S_SH1: state_d = S_SH2;
            S_SH2: state_d = S_SH3;
            S_SH3: begin
                state_d = S_COUNT;
                tick_d  = TICK_RELOAD;
            end
            S_COUNT: begin
                if (tick_q != '0) begin
                    tick_d = tick_q - TICK_ONE;
                end else if (bus.q != 4'd0) begin
                    tick_d = TICK_RELOAD;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
        end
    end

    // The decrement pulse needs the live datapath value to stop at zero.
    assign bus.shift_ena = (state_q[3:2] == 2'b01);
    assign bus.count_ena = (state_q == S_COUNT) && (tick_q == '0) && (bus.q != 4'd0);
    assign bus.counting  = (state_q == S_COUNT);
    assign bus.done      = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_shift_count_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_count_timer_ctrl : directed bench with a behavioural 4-bit datapath
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_shift_count_timer_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    logic [3:0] q_model = 4'd0;

    shift_count_timer_ctrl_if bus ();

    shift_count_timer_ctrl #(
        .PATTERN (4'b1101),
        .TICKS   (4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External shift/down-count datapath
    always_ff @(posedge clk) begin
        if (bus.shift_ena) begin
            q_model <= {q_model[2:0], bus.data};
        end else if (bus.count_ena) begin
            q_model <= q_model - 4'd1;
        end
    end
    assign bus.q = q_model;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        bus.data = b;
        step();
    endtask

    task automatic send_nib(input logic [3:0] v);
        send(v[3]);
        send(v[2]);
        send(v[1]);
        send(v[0]);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_shift"},    {31'd0, bus.shift_ena}, 32'd0);
        check({tag, "_count"},    {31'd0, bus.count_ena}, 32'd0);
        check({tag, "_counting"}, {31'd0, bus.counting},  32'd0);
        check({tag, "_done"},     {31'd0, bus.done},      32'd0);
    endtask

    task automatic run_count(input int ack_cyc, output int cyc, output logic [31:0] mask);
        cyc  = 0;
        mask = '0;
        while (bus.counting === 1'b1 && cyc < 400) begin
            cyc++;
            if (bus.count_ena === 1'b1 && cyc < 32) begin
                mask = mask | (32'd1 << cyc);
            end
            bus.ack = (cyc == ack_cyc);
            bus.data = 1'b0;
            step();
        end
        bus.ack = 1'b0;
        check("count_timeout", {31'd0, (cyc < 400)}, 32'd1);
    endtask

    task automatic ack_done();
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
    endtask

    initial begin
        int          cyc;
        logic [31:0] mask;
        int          acc;
        int          dn;
        logic [9:0]  stream;

        reset    = 1'b1;
        bus.data = 1'b0;
        bus.ack  = 1'b0;
        step();
        step();
        check_quiet("reset");
        reset = 1'b0;

        acc = 0;
        for (int i = 0; i < 8; i++) begin
            send(1'b0);
            acc += int'(bus.shift_ena) + int'(bus.counting) + int'(bus.done);
        end
        check("idle_quiet", acc, 0);

        // Main run: delay 2, ack pulsed mid-COUNT
        send_nib(4'b1101);
        check("detect", {31'd0, bus.shift_ena}, 32'd1);
        acc = 0;
        for (int i = 3; i >= 0; i--) begin
            acc += int'(bus.shift_ena);
            send(i == 1);
        end
        check("shift_len", acc, 4);
        check("shift_end", {31'd0, bus.shift_ena}, 32'd0);
        check("count_enter", {31'd0, bus.counting}, 32'd1);
        run_count(2, cyc, mask);
        check("count_cycles_d2", cyc, 12);
        check("pulse_mask_d2", mask, 32'h110);
        check("done_rise", {31'd0, bus.done}, 32'd1);

        // Hold in DONE with ack low while the pattern streams past
        stream = 10'b1101000000;
        dn  = 0;
        acc = 0;
        for (int i = 9; i >= 0; i--) begin
            dn += int'(bus.done);
            send(stream[i]);
            acc += int'(bus.shift_ena);
        end
        check("done_hold", dn, 10);
        check("done_ignore_data", acc, 0);
        check("done_still", {31'd0, bus.done}, 32'd1);
        bus.data = 1'b0;
        ack_done();
        check_quiet("after_ack");

        bus.ack = 1'b1;
        send(1'b0);
        bus.ack = 1'b0;
        check_quiet("ack_idle");

        // Zero delay
        send_nib(4'b1101);
        send_nib(4'b0000);
        check("count_enter_d0", {31'd0, bus.counting}, 32'd1);
        run_count(0, cyc, mask);
        check("count_cycles_d0", cyc, 4);
        check("pulse_mask_d0", mask, 32'h0);
        check("done_d0", {31'd0, bus.done}, 32'd1);
        ack_done();

        // Overlap 1,1,1,0,1
        send(1'b1); send(1'b1); send(1'b1); send(1'b0);
        check("ovl1_early", {31'd0, bus.shift_ena}, 32'd0);
        send(1'b1);
        check("ovl1_detect", {31'd0, bus.shift_ena}, 32'd1);
        send_nib(4'b0000);
        run_count(0, cyc, mask);
        ack_done();

        // 1,1,0,0,1,1,0,1 detected only after the 8th bit
        stream = 10'b0011001101;
        acc = 0;
        for (int i = 7; i >= 1; i--) begin
            send(stream[i]);
            acc += int'(bus.shift_ena);
        end
        check("ovl2_early", acc, 0);
        send(1'b1);
        check("ovl2_detect", {31'd0, bus.shift_ena}, 32'd1);
        send_nib(4'b0001);
        run_count(0, cyc, mask);
        check("count_cycles_d1", cyc, 8);
        check("pulse_mask_d1", mask, 32'h10);
        ack_done();

        // Reset in SHIFT2
        send_nib(4'b1101);
        send(1'b1);
        send(1'b0);
        check("pre_reset_shift", {31'd0, bus.shift_ena}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_quiet("reset_shift2");
        send(1'b1);
        send(1'b1);
        check("redetect_wait", {31'd0, bus.shift_ena}, 32'd0);
        send(1'b0);
        send(1'b1);
        check("redetect", {31'd0, bus.shift_ena}, 32'd1);

        // Reset in COUNT
        send_nib(4'b1111);
        for (int i = 0; i < 5; i++) send(1'b0);
        check("pre_reset_count", {31'd0, bus.counting}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_quiet("reset_count");
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(1'b1);
            acc += int'(bus.shift_ena) + int'(bus.count_ena) + int'(bus.counting) + int'(bus.done);
        end
        check("post_reset_quiet", acc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
